// File: rtl/serial_subtractor_if.sv
// Handshake and operand/result bundle for the bit-serial subtractor.
// The controller side uses the master modport, the subtractor the slave modport.
interface serial_subtractor_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             borrow_in;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             borrow_out;
  logic             overflow;

  modport master (
    output start, a, b, borrow_in,
    input  busy, done, diff, borrow_out, overflow
  );

  modport slave (
    input  start, a, b, borrow_in,
    output busy, done, diff, borrow_out, overflow
  );
endinterface

// File: rtl/serial_subtractor.sv
// Bit-serial two's-complement subtractor: diff = a - b - borrow_in, LSB first,
// one full-subtractor cell plus a borrow flop, with a start/busy/done handshake.
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  serial_subtractor_if.slave bus
);

  localparam int               CNT_W    = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q,      state_d;
  logic [CNT_W-1:0] cnt_q,        cnt_d;
  logic [WIDTH-1:0] a_sr_q,       a_sr_d;
  logic [WIDTH-1:0] b_sr_q,       b_sr_d;
  logic [WIDTH-1:0] work_q,       work_d;
  logic             br_q,         br_d;
  logic             busy_q,       busy_d;
  logic             done_q,       done_d;
  logic [WIDTH-1:0] diff_q,       diff_d;
  logic             borrow_out_q, borrow_out_d;
  logic             overflow_q,   overflow_d;

  logic             d_bit;
  logic             br_next;
  logic [WIDTH-1:0] work_shift;

  // Full-subtractor cell: returns {borrow_out, difference}.
  function automatic logic [1:0] full_sub(input logic x, input logic y, input logic bi);
    logic bo;
    logic d;
    d  = x ^ y ^ bi;
    bo = (~x & y) | (~(x ^ y) & bi);
    return {bo, d};
  endfunction

  always_comb begin
    {br_next, d_bit} = full_sub(a_sr_q[0], b_sr_q[0], br_q);
    work_shift       = {d_bit, work_q[WIDTH-1:1]};
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    a_sr_d       = a_sr_q;
    b_sr_d       = b_sr_q;
    work_d       = work_q;
    br_d         = br_q;
    busy_d       = busy_q;
    done_d       = 1'b0;
    diff_d       = diff_q;
    borrow_out_d = borrow_out_q;
    overflow_d   = overflow_q;

    unique case (state_q)
      IDLE, DONE: begin
        if (bus.start) begin
          state_d = RUN;
          a_sr_d  = bus.a;
          b_sr_d  = bus.b;
          br_d    = bus.borrow_in;
          work_d  = '0;
          cnt_d   = '0;
          busy_d  = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end

      RUN: begin
        a_sr_d = a_sr_q >> 1;
        b_sr_d = b_sr_q >> 1;
        br_d   = br_next;
        work_d = work_shift;
        if (cnt_q == LAST_BIT) begin
          // Last bit: br_q is the borrow into the MSB, br_next the borrow out.
          state_d      = DONE;
          busy_d       = 1'b0;
          done_d       = 1'b1;
          diff_d       = work_shift;
          borrow_out_d = br_next;
          overflow_d   = br_q ^ br_next;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      a_sr_q       <= '0;
      b_sr_q       <= '0;
      work_q       <= '0;
      br_q         <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      diff_q       <= '0;
      borrow_out_q <= 1'b0;
      overflow_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      a_sr_q       <= a_sr_d;
      b_sr_q       <= b_sr_d;
      work_q       <= work_d;
      br_q         <= br_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      diff_q       <= diff_d;
      borrow_out_q <= borrow_out_d;
      overflow_q   <= overflow_d;
    end
  end

  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.diff       = diff_q;
  assign bus.borrow_out = borrow_out_q;
  assign bus.overflow   = overflow_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed and random bench for serial_subtractor at WIDTH=8.
module tb_serial_subtractor;

  localparam int W = 8;

  logic clk;
  logic rst_n;
  int   n_vec;
  int   n_err;
  int   lat;
  int   busy_n;

  serial_subtractor_if #(.WIDTH(W)) bus ();

  serial_subtractor #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drive a request for one edge; operands are scrambled afterwards.
  task automatic launch(input logic [7:0] a, input logic [7:0] b, input logic bin);
    @(negedge clk);
    bus.start = 1'b1; bus.a = a; bus.b = b; bus.borrow_in = bin;
    @(posedge clk); #1;
    bus.start = 1'b0;
    bus.a = 8'($urandom); bus.b = 8'($urandom); bus.borrow_in = 1'($urandom);
  endtask

  // Called just after an edge; returns edges until done and busy-high samples seen.
  task automatic wait_done(output int l, output int bn);
    l = 0; bn = 0;
    while (!bus.done && l < 20) begin
      if (bus.busy) bn++;
      @(posedge clk); #1;
      l++;
    end
  endtask

  task automatic check_result(input string tag, input logic [7:0] a, input logic [7:0] b,
                              input logic bin);
    logic [8:0] wide;
    int         s;
    wide = {1'b0, a} - {1'b0, b} - {8'd0, bin};
    s    = int'($signed(a)) - int'($signed(b)) - int'(bin);
    chk({tag, ".done"}, 32'(bus.done), 32'd1);
    chk({tag, ".diff"}, 32'(bus.diff), 32'(wide[7:0]));
    chk({tag, ".bout"}, 32'(bus.borrow_out), 32'(wide[8]));
    chk({tag, ".ovf"},  32'(bus.overflow), 32'((s > 127 || s < -128) ? 1 : 0));
  endtask

  initial begin
    n_vec = 0; n_err = 0;
    rst_n = 1'b0;
    bus.start = 1'b0; bus.a = '0; bus.b = '0; bus.borrow_in = 1'b0;
    #1;
    chk("rst.busy", 32'(bus.busy), 0);
    chk("rst.done", 32'(bus.done), 0);
    chk("rst.diff", 32'(bus.diff), 0);
    chk("rst.bout", 32'(bus.borrow_out), 0);
    chk("rst.ovf",  32'(bus.overflow), 0);
    repeat (2) @(posedge clk);
    @(negedge clk); rst_n = 1'b1;

    // 1: latency, busy length, one-cycle done
    launch(8'h5A, 8'h21, 1'b0);
    wait_done(lat, busy_n);
    chk("t1.lat",  32'(lat), 8);
    chk("t1.busy", 32'(busy_n), 8);
    chk("t1.diff_const", 32'(bus.diff), 32'h39);
    check_result("t1", 8'h5A, 8'h21, 1'b0);
    @(posedge clk); #1;
    chk("t1.done_pulse", 32'(bus.done), 0);
    chk("t1.hold", 32'(bus.diff), 32'h39);

    // 2..4: borrow, overflow, borrow_in edge cases
    launch(8'h10, 8'h20, 1'b0); wait_done(lat, busy_n);
    chk("t2.diff_const", 32'(bus.diff), 32'hF0);
    check_result("t2", 8'h10, 8'h20, 1'b0);
    launch(8'h80, 8'h01, 1'b0); wait_done(lat, busy_n);
    chk("t3a.ovf_const", 32'(bus.overflow), 1);
    check_result("t3a", 8'h80, 8'h01, 1'b0);
    launch(8'h7F, 8'hFF, 1'b0); wait_done(lat, busy_n);
    chk("t3b.diff_const", 32'(bus.diff), 32'h80);
    check_result("t3b", 8'h7F, 8'hFF, 1'b0);
    launch(8'h00, 8'h00, 1'b1); wait_done(lat, busy_n);
    chk("t4.diff_const", 32'(bus.diff), 32'hFF);
    check_result("t4", 8'h00, 8'h00, 1'b1);

    // 5: start while busy ignored, then back-to-back accept in the done cycle
    launch(8'h33, 8'h11, 1'b0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    bus.start = 1'b1; bus.a = 8'hFF; bus.b = 8'h00; bus.borrow_in = 1'b0;
    @(posedge clk); #1;
    bus.start = 1'b0;
    chk("t5.hold_run", 32'(bus.diff), 32'hFF);
    wait_done(lat, busy_n);
    chk("t5.lat", 32'(lat), 5);
    chk("t5.diff_const", 32'(bus.diff), 32'h22);
    bus.start = 1'b1; bus.a = 8'h7F; bus.b = 8'hFF; bus.borrow_in = 1'b0;
    @(posedge clk); #1;
    bus.start = 1'b0;
    chk("t5.b2b_busy", 32'(bus.busy), 1);
    chk("t5.b2b_done", 32'(bus.done), 0);
    chk("t5.b2b_hold", 32'(bus.diff), 32'h22);
    wait_done(lat, busy_n);
    chk("t5.b2b_lat", 32'(lat), 8);
    check_result("t5b", 8'h7F, 8'hFF, 1'b0);

    // 6: async reset mid-operation
    launch(8'h12, 8'h34, 1'b0);
    repeat (3) begin @(posedge clk); #1; end
    #2 rst_n = 1'b0;
    #1;
    chk("t6.busy", 32'(bus.busy), 0);
    chk("t6.done", 32'(bus.done), 0);
    chk("t6.diff", 32'(bus.diff), 0);
    chk("t6.bout", 32'(bus.borrow_out), 0);
    chk("t6.ovf",  32'(bus.overflow), 0);
    @(negedge clk); rst_n = 1'b1;
    wait_done(lat, busy_n);
    chk("t6.no_done", 32'(lat), 20);
    launch(8'h05, 8'h07, 1'b0); wait_done(lat, busy_n);
    chk("t6.diff_const", 32'(bus.diff), 32'hFE);
    chk("t6.bout_const", 32'(bus.borrow_out), 1);
    check_result("t6", 8'h05, 8'h07, 1'b0);

    // Random operand sets
    for (int i = 0; i < 1000; i++) begin
      logic [7:0] ra;
      logic [7:0] rb;
      logic       rbi;
      ra  = 8'($urandom);
      rb  = 8'($urandom);
      rbi = 1'($urandom);
      launch(ra, rb, rbi);
      wait_done(lat, busy_n);
      chk("rnd.lat", 32'(lat), 8);
      check_result("rnd", ra, rb, rbi);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
